nonrestoring_divider: RTL and testbench

//  Sequential non-restoring integer divider; the division counterpart of the ALU's Booth multiplier.

---
 rtl/nonrestoring_divider_pkg.sv | 13 +
 rtl/nonrestoring_divider_nr_div_step.sv | 23 ++
 rtl/nonrestoring_divider.sv | 143 ++++++++++++++
 tb/tb_nonrestoring_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// State encodings and default width are common with the Booth multiplier.
package nonrestoring_divider_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ITER = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/nonrestoring_divider_nr_div_step.sv
// One non-restoring iteration: shift {A,Q} left, then add or subtract M.
// Purely combinational so it can be chained for an unrolled variant.
module nr_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_a,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH:0]   o_a,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH:0] w_a_sh;
   logic [WIDTH:0] w_m_ext;

   assign w_a_sh  = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
   assign w_m_ext = {1'b0, i_m};

   // Sign of the old partial remainder picks the operation
   assign o_a = i_a[WIDTH] ? (w_a_sh + w_m_ext) : (w_a_sh - w_m_ext);
   assign o_q = {i_q[WIDTH-2:0], ~o_a[WIDTH]};

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider: quotient on lo, remainder on hi.
// WIDTH iteration cycles plus one correction cycle per operation.
module nonrestoring_divider
   import nonrestoring_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH);

   div_state_t r_state;
   div_state_t w_next;

   logic [WIDTH:0]   r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_cnt;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_zero;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;

   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic             w_dvs_zero;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH:0]   w_step_a;
   logic [WIDTH-1:0] w_step_q;
   logic [WIDTH-1:0] w_rem;
   logic             w_last;

   assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
   assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
   assign w_dvs_zero = (divisor == '0);
   // -MIN wraps to MIN, which read unsigned is the correct magnitude
   assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
   assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   assign w_rem      = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m)
                                  : r_a[WIDTH-1:0];

   nr_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_a (r_a),
      .i_q (r_q),
      .i_m (r_m),
      .o_a (w_step_a),
      .o_q (w_step_q)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         DIV_IDLE: if (start) w_next = w_dvs_zero ? DIV_FIX : DIV_ITER;
         DIV_ITER: if (w_last) w_next = DIV_FIX;
         DIV_FIX:  w_next = DIV_IDLE;
         default:  w_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) r_state <= DIV_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_a    <= '0;
         r_q    <= '0;
         r_m    <= '0;
         r_cnt  <= '0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         r_zero <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         r_lo   <= '0;
         r_hi   <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            DIV_IDLE: begin
               if (start) begin
                  r_m    <= w_dvs_mag;
                  // Raw dividend is kept for the divide-by-zero result
                  r_q    <= w_dvs_zero ? dividend : w_dvd_mag;
                  r_a    <= '0;
                  r_cnt  <= '0;
                  r_qneg <= w_dvd_neg ^ w_dvs_neg;
                  r_rneg <= w_dvd_neg;
                  r_zero <= w_dvs_zero;
                  r_busy <= 1'b1;
                  r_dbz  <= 1'b0;
               end
            end
            DIV_ITER: begin
               r_a   <= w_step_a;
               r_q   <= w_step_q;
               r_cnt <= r_cnt + CW'(1);
            end
            DIV_FIX: begin
               if (r_zero) begin
                  r_lo  <= '1;
                  r_hi  <= r_q;
                  r_dbz <= 1'b1;
               end else begin
                  r_lo <= r_qneg ? -r_q : r_q;
                  r_hi <= r_rneg ? -w_rem : w_rem;
               end
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign lo          = r_lo;
   assign hi          = r_hi;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider: directed vectors plus a few model-checked pairs.
module tb_nonrestoring_divider;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] lo;
   logic [31:0] hi;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dbz;
      int          lat;
      int          scyc;
   } exp_t;

   exp_t sbq[$];

   nonrestoring_divider #(.WIDTH(32)) dut (
      .clock       (clk),
      .clear       (clear),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .lo          (lo),
      .hi          (hi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports completion
   always @(negedge clk) begin
      if (!clear && done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("lo", lo, e.lo);
            chk("hi", hi, e.hi);
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
            chk("latency", cyc - e.scyc, e.lat);
         end
      end
   end

   task automatic go(input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] elo, input logic [31:0] ehi,
                     input logic edbz, input bit push);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL wait_idle actual=busy required=idle");
      end
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      e.lo   = elo;
      e.hi   = ehi;
      e.dbz  = edbz;
      e.lat  = (b == 32'd0) ? 1 : 33;
      e.scyc = cyc;
      if (push) sbq.push_back(e);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      if (b != 32'd0) chk("busy_after_start", {31'b0, busy}, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic        sg;
      int          n;

      clear     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_hi", hi, 32'd0);
      clear = 1'b0;

      go(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1);
      go(1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 1);
      go(1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 0, 1);
      go(1, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 1);
      go(1, 32'd0, -32'sd5, 32'd0, 32'd0, 0, 1);
      go(0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 1);
      go(0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1);
      go(1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 1);
      go(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 1);
      go(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 1);
      go(0, 32'd3, 32'd10, 32'd0, 32'd3, 0, 1);

      // Abort mid-operation: nothing may complete afterwards
      go(0, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 0);
      repeat (9) @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clr_busy", {31'b0, busy}, 32'd0);
      chk("clr_done", {31'b0, done}, 32'd0);
      chk("clr_lo", lo, 32'd0);
      chk("clr_hi", hi, 32'd0);
      repeat (40) @(negedge clk);

      go(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 1);

      // Start while busy must be ignored
      go(0, 32'd77, 32'd5, 32'd15, 32'd2, 0, 1);
      repeat (5) @(negedge clk);
      start     = 1'b1;
      is_signed = 1'b1;
      dividend  = 32'd999;
      divisor   = 32'd1;
      @(negedge clk);
      start = 1'b0;
      go(1, -32'sd77, -32'sd5, 32'd15, 32'hFFFFFFFE, 0, 1);

      for (int i = 0; i < 30; i++) begin
         sg = 1'($urandom % 2);
         a  = $urandom;
         b  = $urandom >> ($urandom % 32);
         if (b == 32'd0) b = 32'd1;
         if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         if (sg) go(1, a, b, 32'($signed(a) / $signed(b)),
                    32'($signed(a) % $signed(b)), 0, 1);
         else    go(0, a, b, a / b, a % b, 0, 1);
      end

      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d required=0", sbq.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
